sig_host_port: RTL and testbench

SIG_HOST_PORT -- requirements
Module: sig_host_port

---
 rtl/sig_host_port.sv | 166 ++++++++++++++++
 tb/tb_sig_host_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sig_host_port.sv
// sig_host_port -- host-side signature port for a test core.
//
// A four-register window at BASE_ADDR lets the core under test push
// signature words into a FIFO, clear the overflow flag and request the end
// of the test. Once the end of the test is requested, the buffered words
// are drained to a downstream reader before HALT is raised.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   DMEM_AW*/DMEM_WDATA  core write channel (one write per cycle)
//   DMEM_ARADDR          core read address (reads are combinational)
//   DMEM_RDATA/DMEM_HIT  read data and window-hit flag
//   SIG_T*               signature stream (valid/ready)
//   HALT                 test finished, all words drained
//   OVERFLOW             sticky, a signature word was dropped
module sig_host_port #(
  parameter logic [31:0] BASE_ADDR  = 32'hF0000000,
  parameter logic [31:0] HALT_MAGIC = 32'hCAFECAFE,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DMEM_AWADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic        DMEM_AWVALID,
  input  logic [31:0] DMEM_ARADDR,
  output logic [31:0] DMEM_RDATA,
  output logic        DMEM_HIT,
  output logic [31:0] SIG_TDATA,
  output logic        SIG_TVALID,
  input  logic        SIG_TREADY,
  output logic        HALT,
  output logic        OVERFLOW
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e        r_state;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_halt;
  logic [31:0]   r_mem [FIFO_DEPTH];

  // Word-granular offsets from the window base; byte lanes are ignored.
  logic [29:0] w_wword;
  logic [29:0] w_rword;
  logic        w_whit;
  logic        w_wr_ctrl;
  logic        w_wr_sig;
  logic        w_wr_clr;
  logic        w_run;
  logic        w_pop;
  logic        w_full;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_evt;
  logic        w_halt_req;
  logic [CW-1:0] w_count_nxt;
  logic [14:0] w_count15;
  logic        w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{DMEM_AWADDR[1:0], DMEM_ARADDR[1:0]};

  assign w_wword   = DMEM_AWADDR[31:2] - BASE_ADDR[31:2];
  assign w_whit    = DMEM_AWVALID && (w_wword[29:2] == 28'd0);
  assign w_wr_ctrl = w_whit && (w_wword[1:0] == 2'd0);
  assign w_wr_sig  = w_whit && (w_wword[1:0] == 2'd1);
  assign w_wr_clr  = w_whit && (w_wword[1:0] == 2'd2);

  // Only RUN accepts writes; DRAIN and HALTED ignore everything.
  assign w_run      = (r_state == StRun);
  assign w_pop      = (r_count != '0) && SIG_TREADY;
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push_req = w_wr_sig && w_run;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_evt  = w_push_req && w_full && !w_pop;
  assign w_halt_req = w_wr_ctrl && w_run && (DMEM_WDATA == HALT_MAGIC);

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StRun;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      // Overflow event beats a concurrent clear.
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (w_wr_clr && w_run) begin
        r_overflow <= 1'b0;
      end

      unique case (r_state)
        StRun: begin
          if (w_halt_req) begin
            if (w_count_nxt != '0) begin
              r_state <= StDrain;
            end else begin
              r_state <= StHalted;
              r_halt  <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (w_count_nxt == '0) begin
            r_state <= StHalted;
            r_halt  <= 1'b1;
          end
        end
        StHalted: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= StRun;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= DMEM_WDATA;
  end

  assign SIG_TVALID = (r_count != '0);
  assign SIG_TDATA  = r_mem[r_rd_ptr];
  assign HALT       = r_halt;
  assign OVERFLOW   = r_overflow;

  assign w_rword   = DMEM_ARADDR[31:2] - BASE_ADDR[31:2];
  assign DMEM_HIT  = (w_rword[29:2] == 28'd0);
  assign w_count15 = 15'(r_count);

  always_comb begin
    DMEM_RDATA = 32'd0;
    if (DMEM_HIT) begin
      unique case (w_rword[1:0])
        2'd0: DMEM_RDATA = {30'd0, r_state};
        2'd1: DMEM_RDATA = SIG_TVALID ? SIG_TDATA : 32'd0;
        2'd2: DMEM_RDATA = 32'd0;
        2'd3: DMEM_RDATA = {16'd0, w_count15, r_overflow};
        default: DMEM_RDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_host_port.sv
`timescale 1ns/1ps
module tb_sig_host_port;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'hF0000000;
  localparam logic [31:0] MAGIC = 32'hCAFECAFE;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] DMEM_AWADDR, DMEM_WDATA, DMEM_ARADDR, DMEM_RDATA, SIG_TDATA;
  logic        DMEM_AWVALID, DMEM_HIT, SIG_TVALID, SIG_TREADY, HALT, OVERFLOW;

  sig_host_port #(
    .BASE_ADDR (BASE),
    .HALT_MAGIC(MAGIC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK         (clk),
    .RST         (RST),
    .DMEM_AWADDR (DMEM_AWADDR),
    .DMEM_WDATA  (DMEM_WDATA),
    .DMEM_AWVALID(DMEM_AWVALID),
    .DMEM_ARADDR (DMEM_ARADDR),
    .DMEM_RDATA  (DMEM_RDATA),
    .DMEM_HIT    (DMEM_HIT),
    .SIG_TDATA   (SIG_TDATA),
    .SIG_TVALID  (SIG_TVALID),
    .SIG_TREADY  (SIG_TREADY),
    .HALT        (HALT),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of the FIFO, phase (0 run, 1 drain, 2 halted), sticky flag.
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  int          mst  = 0;
  bit          movf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode an address into a register index 0..3, or -1 if outside the window.
  function automatic int reg_idx(input logic [31:0] a);
    logic [31:0] aw;
    aw = {a[31:2], 2'b00};
    if (aw >= BASE && aw <= BASE + 32'd12) return int'((aw - BASE) / 4);
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (reg_idx(a))
      0: return 32'(mst);
      1: return (mq.size() > 0) ? mq[0] : 32'd0;
      3: return 32'(mq.size()) * 2 + 32'(movf);
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (!RST && SIG_TVALID && SIG_TREADY) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_pop: got %h, expected no word at %0t", SIG_TDATA, $time);
      end else begin
        chk("sb_order", SIG_TDATA, sb[0]);
        void'(sb.pop_front());
      end
    end
  end

  // One clock cycle: drive inputs, step the model across the edge, then check.
  task automatic cyc(input bit wv, input logic [31:0] wa, input logic [31:0] wd,
                     input bit rdy, input logic [31:0] ra);
    bit pop, sigw, clrw, ctrlw, drop;
    int idx;
    DMEM_AWVALID = wv;
    DMEM_AWADDR  = wa;
    DMEM_WDATA   = wd;
    SIG_TREADY   = rdy;
    idx   = reg_idx(wa);
    pop   = (mq.size() > 0) && rdy;
    sigw  = wv && idx == 1 && mst == 0;
    clrw  = wv && idx == 2 && mst == 0;
    ctrlw = wv && idx == 0 && mst == 0 && wd == MAGIC;
    drop  = sigw && mq.size() == DEPTH && !pop;
    if (pop) void'(mq.pop_front());
    if (sigw && !drop) begin
      mq.push_back(wd);
      sb.push_back(wd);
    end
    if (drop) movf = 1'b1;
    else if (clrw) movf = 1'b0;
    if (ctrlw) mst = (mq.size() > 0) ? 1 : 2;
    else if (mst == 1 && mq.size() == 0) mst = 2;
    @(posedge clk);
    #1;
    DMEM_ARADDR = ra;
    #1;
    chk("rdata", DMEM_RDATA, model_read(ra));
    chk("hit", 32'(DMEM_HIT), 32'(reg_idx(ra) >= 0));
    chk("halt", 32'(HALT), 32'(mst == 2));
    chk("overflow", 32'(OVERFLOW), 32'(movf));
    chk("tvalid", 32'(SIG_TVALID), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("tdata", SIG_TDATA, mq[0]);
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    DMEM_AWVALID = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b0;
    mq.delete();
    sb.delete();
    mst  = 0;
    movf = 1'b0;
    DMEM_ARADDR = BASE + 32'd12;
    #1;
    chk("rst_status", DMEM_RDATA, 32'd0);
    chk("rst_tvalid", 32'(SIG_TVALID), 32'd0);
    chk("rst_halt", 32'(HALT), 32'd0);
    DMEM_ARADDR = BASE;
    #1;
    chk("rst_ctrl", DMEM_RDATA, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r <= 5)      a = BASE + 32'd4;
    else if (r == 6) a = BASE + 32'd8;
    else if (r == 7) a = BASE;
    else if (r == 8) a = BASE + 32'd12;
    else             a = ($urandom_range(0, 1) == 1) ? BASE + 32'd16 : BASE - 32'd4;
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST          = 1'b1;
    DMEM_AWVALID = 1'b0;
    DMEM_AWADDR  = 32'd0;
    DMEM_WDATA   = 32'd0;
    DMEM_ARADDR  = 32'd0;
    SIG_TREADY   = 1'b0;
    do_reset();

    // Two words streamed straight through.
    cyc(1, BASE + 4, 32'h11111111, 1, BASE + 12);
    cyc(1, BASE + 4, 32'h22222222, 1, BASE + 12);
    cyc(0, 32'd0, 32'd0, 1, BASE + 12);
    cyc(0, 32'd0, 32'd0, 1, BASE + 12);

    // Fill past capacity, then clear the sticky flag.
    for (int i = 0; i < 17; i++) cyc(1, BASE + 4, 32'hA000_0000 + 32'(i), 0, BASE + 12);
    cyc(1, BASE + 8, 32'h5A5A5A5A, 0, BASE + 12);
    // Full FIFO with simultaneous pop and push.
    cyc(1, BASE + 4, 32'hBEEF0001, 1, BASE + 12);
    for (int i = 0; i < 18; i++) cyc(0, 32'd0, 32'd0, 1, BASE + 4);

    // Drain: three words, halt request, ignored SIG write, then release.
    for (int i = 0; i < 3; i++) cyc(1, BASE + 4, 32'hC000_0000 + 32'(i), 0, BASE + 12);
    cyc(1, BASE, MAGIC, 0, BASE);
    cyc(1, BASE + 4, 32'hDEADDEAD, 0, BASE + 12);
    for (int i = 0; i < 4; i++) cyc(0, 32'd0, 32'd0, 1, BASE);
    cyc(1, BASE + 4, 32'h0BAD0BAD, 1, BASE + 12);
    do_reset();

    // Halt from empty, and a non-magic CTRL write.
    cyc(1, BASE, MAGIC, 0, BASE);
    cyc(0, 32'd0, 32'd0, 0, BASE);
    do_reset();
    cyc(1, BASE, 32'h12345678, 0, BASE);

    // Reset in the middle of a drain.
    cyc(1, BASE + 4, 32'h1, 0, BASE + 12);
    cyc(1, BASE + 4, 32'h2, 0, BASE + 12);
    cyc(1, BASE, MAGIC, 0, BASE);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d, ra;
      bit rdy;
      a   = rand_addr();
      d   = $urandom();
      if (reg_idx(a) == 0 && $urandom_range(0, 3) == 0) d = MAGIC;
      rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ra  = rand_addr();
      cyc($urandom_range(0, 3) != 0, a, d, rdy, ra);
      if ((mst == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
